// File: rtl/bank_rr_grant_ctrl.sv
// bank_rr_grant_ctrl: round-robin bank grant stage wrapped around a rotating priority encoder
module bank_rr_grant_ctrl #(
    parameter int NUM_BNK_TOT = 16,
    parameter int IDX_W       = $clog2(NUM_BNK_TOT)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_BNK_TOT-1:0]                  bank_req,
    input  logic [NUM_BNK_TOT-1:0]                  bank_block,
    output logic [NUM_BNK_TOT-1:0]                  pe_in,
    input  logic [NUM_BNK_TOT-1:0][NUM_BNK_TOT-1:0] pe_out,
    output logic                                    cmd_valid,
    input  logic                                    cmd_ready,
    output logic [NUM_BNK_TOT-1:0]                  grant_oh,
    output logic [IDX_W-1:0]                        grant_idx,
    output logic [IDX_W-1:0]                        rr_ptr,
    output logic                                    pe_err
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t                 state_q;
    logic [NUM_BNK_TOT-1:0] grant_oh_q;
    logic [IDX_W-1:0]       grant_idx_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic                   pe_err_q;
    logic                   accept;
    logic                   cancel;
    logic                   load;
    logic                   load_err;
    logic [IDX_W-1:0]       nxt_ptr;
    logic [IDX_W-1:0]       sel_row;
    logic [NUM_BNK_TOT-1:0] cand;
    logic [IDX_W-1:0]       cand_idx;
    assign cmd_valid = state_q == HOLD;
    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;
    assign rr_ptr    = rr_ptr_q;
    assign pe_err    = pe_err_q;
    // The held bank is masked so it can never win again in the cycle it is held or accepted.
    assign pe_in    = bank_req & ~bank_block & ~(cmd_valid ? grant_oh_q : '0);
    assign accept   = cmd_valid & cmd_ready;
    assign cancel   = cmd_valid & ~cmd_ready & (~bank_req[grant_idx_q] | bank_block[grant_idx_q]);
    assign nxt_ptr  = (grant_idx_q == IDX_W'(NUM_BNK_TOT - 1)) ? '0 : grant_idx_q + IDX_W'(1);
    assign sel_row  = accept ? nxt_ptr : rr_ptr_q;
    assign cand     = pe_out[sel_row];
    assign load     = (!cmd_valid || accept) && (|pe_in);
    assign load_err = load && (!$onehot(cand) || |(cand & ~pe_in));
    // Binary index of the candidate's single set bit; zero when the candidate is empty.
    always_comb begin
        cand_idx = '0;
        for (int i = 0; i < NUM_BNK_TOT; i++)
            if (cand[i]) cand_idx = IDX_W'(i);
    end
    // Grant FSM: IDLE/HOLD with registered grant, pointer advance on accept, sticky encoder error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            pe_err_q    <= 1'b0;
        end else begin
            if (accept) rr_ptr_q <= nxt_ptr;
            if (load && !load_err) begin
                state_q     <= HOLD;
                grant_oh_q  <= cand;
                grant_idx_q <= cand_idx;
            end else if (load || accept || cancel) begin
                state_q     <= IDLE;
                grant_oh_q  <= '0;
                grant_idx_q <= '0;
            end
            if (load_err) pe_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bank_rr_grant_ctrl.sv
// tb_bank_rr_grant_ctrl: directed scenario bench for the round-robin bank grant stage
module tb_bank_rr_grant_ctrl;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      bank_req = '0;
    logic [15:0]      bank_block = '0;
    logic [15:0]      pe_in;
    logic [15:0][15:0] pe_out;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [15:0]      grant_oh;
    logic [3:0]       grant_idx;
    logic [3:0]       rr_ptr;
    logic             pe_err;
    logic             force_en = 1'b0;
    logic [15:0]      force_val = '0;
    int               n_chk = 0;
    int               n_fail = 0;

    bank_rr_grant_ctrl #(.NUM_BNK_TOT(16)) dut (
        .clk(clk), .rst_n(rst_n), .bank_req(bank_req), .bank_block(bank_block),
        .pe_in(pe_in), .pe_out(pe_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .grant_oh(grant_oh), .grant_idx(grant_idx), .rr_ptr(rr_ptr), .pe_err(pe_err)
    );

    always #5 clk = ~clk;

    // Reference rotating priority encoder: row r picks the first eligible bank at or above r, wrapping.
    function automatic logic [15:0] rr_enc(input logic [15:0] v, input int r);
        for (int k = 0; k < 16; k++)
            if (v[(r + k) % 16]) return 16'b1 << ((r + k) % 16);
        return '0;
    endfunction

    always_comb begin
        for (int r = 0; r < 16; r++) pe_out[r] = rr_enc(pe_in, r);
        if (force_en) pe_out[0] = force_val;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({cmd_valid, grant_oh, grant_idx, rr_ptr, pe_err} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b oh=%h idx=%0d ptr=%0d err=%0b, want all 0", cmd_valid, grant_oh, grant_idx, rr_ptr, pe_err);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_chk++;
            if ({cmd_valid, rr_ptr, pe_err} !== 6'd0) begin
                n_fail++;
                $display("FAIL idle_no_req cyc %0d: valid=%0b ptr=%0d err=%0b, want 0 0 0", c, cmd_valid, rr_ptr, pe_err);
            end
        end
    endtask

    task automatic test_two_banks();
        int e_idx[4] = '{2, 5, 2, 5};
        int e_ptr[4] = '{0, 3, 6, 3};
        bank_req = 16'h0024;
        cmd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_chk++;
            if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'(e_idx[c]), 4'(e_ptr[c]), 16'b1 << e_idx[c]}) begin
                n_fail++;
                $display("FAIL two_banks step %0d: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 %0d %0d", c, cmd_valid, grant_idx, rr_ptr, grant_oh, e_idx[c], e_ptr[c]);
            end
        end
        bank_req = 16'h0000;
        step();
        n_chk++;
        if ({cmd_valid, rr_ptr, grant_oh} !== {1'b0, 4'd6, 16'h0000}) begin
            n_fail++;
            $display("FAIL two_banks_drain: valid=%0b ptr=%0d oh=%h, want 0 6 0000", cmd_valid, rr_ptr, grant_oh);
        end
    endtask

    task automatic test_wrap();
        int e_idx[4] = '{15, 0, 1, 2};
        int e_ptr[4] = '{15, 0, 1, 2};
        bank_req = 16'h4000;
        step();
        step();
        n_chk++;
        if ({cmd_valid, rr_ptr} !== {1'b0, 4'd15}) begin
            n_fail++;
            $display("FAIL wrap_setup: valid=%0b ptr=%0d, want 0 15", cmd_valid, rr_ptr);
        end
        bank_req = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            step();
            n_chk++;
            if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'(e_idx[c]), 4'(e_ptr[c]), 16'b1 << e_idx[c]}) begin
                n_fail++;
                $display("FAIL wrap step %0d: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 %0d %0d", c, cmd_valid, grant_idx, rr_ptr, grant_oh, e_idx[c], e_ptr[c]);
            end
        end
        bank_req = 16'h0000;
        step();
        n_chk++;
        if ({cmd_valid, rr_ptr} !== {1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL wrap_drain: valid=%0b ptr=%0d, want 0 3", cmd_valid, rr_ptr);
        end
    endtask

    task automatic test_hold();
        bank_req = 16'h0010;
        cmd_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            bank_req = (c % 2 == 0) ? 16'h0090 : 16'h0010;
            step();
            n_chk++;
            if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'd4, 4'd3, 16'h0010}) begin
                n_fail++;
                $display("FAIL hold_stable cyc %0d: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 4 3 0010", c, cmd_valid, grant_idx, rr_ptr, grant_oh);
            end
        end
        bank_req = 16'h0090;
        cmd_ready = 1'b1;
        step();
        n_chk++;
        if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'd7, 4'd5, 16'h0080}) begin
            n_fail++;
            $display("FAIL hold_accept: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 7 5 0080", cmd_valid, grant_idx, rr_ptr, grant_oh);
        end
        bank_req = 16'h0000;
        step();
        n_chk++;
        if ({cmd_valid, rr_ptr} !== {1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL hold_drain: valid=%0b ptr=%0d, want 0 8", cmd_valid, rr_ptr);
        end
    endtask

    task automatic test_cancel();
        bank_req = 16'h0048;
        cmd_ready = 1'b0;
        step();
        step();
        n_chk++;
        if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'd3, 4'd8, 16'h0008}) begin
            n_fail++;
            $display("FAIL cancel_grant: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 3 8 0008", cmd_valid, grant_idx, rr_ptr, grant_oh);
        end
        bank_block = 16'h0008;
        step();
        n_chk++;
        if ({cmd_valid, rr_ptr, grant_oh} !== {1'b0, 4'd8, 16'h0000}) begin
            n_fail++;
            $display("FAIL cancel_drop: valid=%0b ptr=%0d oh=%h, want 0 8 0000", cmd_valid, rr_ptr, grant_oh);
        end
        step();
        n_chk++;
        if ({cmd_valid, grant_idx, rr_ptr, grant_oh} !== {1'b1, 4'd6, 4'd8, 16'h0040}) begin
            n_fail++;
            $display("FAIL cancel_regrant: valid=%0b idx=%0d ptr=%0d oh=%h, want 1 6 8 0040", cmd_valid, grant_idx, rr_ptr, grant_oh);
        end
    endtask

    task automatic test_reset_mid_hold();
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmd_valid, grant_oh, grant_idx, rr_ptr, pe_err} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: valid=%0b oh=%h idx=%0d ptr=%0d err=%0b, want all 0", cmd_valid, grant_oh, grant_idx, rr_ptr, pe_err);
        end
        bank_req = 16'h0000;
        bank_block = 16'h0000;
        cmd_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pe_err();
        logic [15:0] bad[2] = '{16'h0003, 16'h0002};
        for (int e = 0; e < 2; e++) begin
            force_en = 1'b1;
            force_val = bad[e];
            bank_req = 16'h0001;
            for (int c = 0; c < 3; c++) begin
                step();
                n_chk++;
                if ({pe_err, cmd_valid, grant_oh} !== {1'b1, 1'b0, 16'h0000}) begin
                    n_fail++;
                    $display("FAIL pe_err case %0d cyc %0d: err=%0b valid=%0b oh=%h, want 1 0 0000", e, c, pe_err, cmd_valid, grant_oh);
                end
            end
            #2;
            rst_n = 1'b0;
            #1;
            n_chk++;
            if (pe_err !== 1'b0) begin
                n_fail++;
                $display("FAIL pe_err_clear case %0d: err=%0b, want 0", e, pe_err);
            end
            force_en = 1'b0;
            bank_req = 16'h0000;
            step();
            rst_n = 1'b1;
        end
        bank_req = 16'h0001;
        step();
        n_chk++;
        if ({pe_err, cmd_valid, grant_idx, grant_oh} !== {1'b0, 1'b1, 4'd0, 16'h0001}) begin
            n_fail++;
            $display("FAIL pe_ok_after: err=%0b valid=%0b idx=%0d oh=%h, want 0 1 0 0001", pe_err, cmd_valid, grant_idx, grant_oh);
        end
    endtask

    initial begin
        test_reset();
        test_two_banks();
        test_wrap();
        test_hold();
        test_cancel();
        test_reset_mid_hold();
        test_pe_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bank_rr_grant_ctrl.md
Name: bank_rr_grant_ctrl

Overview:
- Sequential round-robin grant stage that sits directly around the per-bank rotating priority encoder in the command scheduler.
- Drives the encoder input with the eligible-request vector.
- Picks the encoder output row for the current round-robin pointer and registers the one-hot bank grant.
- Holds the grant under a valid/ready handshake toward command issue, then advances the pointer.

Parameters:
- NUM_BNK_TOT, 16, total banks; must equal the encoder's NUM_BNK_TOT; 2..16 supported.
- IDX_W, $clog2(NUM_BNK_TOT), width of the encoded bank index.

Ports:
- clk  input  1  scheduler clock.
- rst_n  input  1  asynchronous active-low reset.
- bank_req  input  NUM_BNK_TOT  per-bank "command ready to issue" flags.
- bank_block  input  NUM_BNK_TOT  per-bank timing block; 1 = ineligible this cycle.
- pe_in  output  NUM_BNK_TOT  combinational eligible vector sent to the encoder input.
- pe_out  input  NUM_BNK_TOT x [0:NUM_BNK_TOT-1]  encoder output rows; row r is one-hot with bank r at highest priority.
- cmd_valid  output  1  registered; a grant is held.
- cmd_ready  input  1  issue stage accepts the grant.
- grant_oh  output  NUM_BNK_TOT  registered one-hot grant; 0 when cmd_valid=0.
- grant_idx  output  IDX_W  registered binary index of grant_oh.
- rr_ptr  output  IDX_W  current round-robin pointer.
- pe_err  output  1  sticky encoder-consistency error.

Behaviour:
- Reset (async assert, sync release): cmd_valid=0, grant_oh=0, grant_idx=0, rr_ptr=0, pe_err=0.
- Eligibility (combinational): pe_in = bank_req & ~bank_block & ~(cmd_valid ? grant_oh : 0). The held or just-accepted bank is never re-selected in the same cycle.
- Define:
  - accept = cmd_valid & cmd_ready.
  - cancel = cmd_valid & ~cmd_ready & (~bank_req[grant_idx] | bank_block[grant_idx]).
- Define sel_row:
  - If accept: row (grant_idx+1) mod NUM_BNK_TOT.
  - Otherwise: row rr_ptr.
- Define cand = pe_out[sel_row].
- States: IDLE (cmd_valid=0), HOLD (cmd_valid=1).
- IDLE:
  - If |pe_in: latch cand into grant_oh and its index into grant_idx, set cmd_valid. Go to HOLD next cycle (1-cycle latency from request to cmd_valid).
  - Else remain IDLE.
  - rr_ptr unchanged.
- HOLD, no accept, no cancel:
  - grant_oh and grant_idx held stable.
  - Changes on other banks are ignored.
- HOLD, accept:
  - rr_ptr <= (grant_idx+1) mod NUM_BNK_TOT. Wrap from NUM_BNK_TOT-1 to 0.
  - If |pe_in: load the new cand the same edge and stay in HOLD. This gives back-to-back grants at one per cycle.
  - Else cmd_valid <= 0, grant_oh <= 0, go to IDLE.
- HOLD, cancel (no accept):
  - cmd_valid <= 0, grant_oh <= 0, rr_ptr unchanged, go to IDLE.
  - Re-arbitration happens on the following cycle.
- accept takes precedence over cancel when both would be true.
- Index encoding: grant_idx is the binary position of the single 1 in cand. Zero if cand=0.
- pe_err is set (sticky until reset) on any cycle where a candidate is being loaded and either:
  - cand is not exactly one-hot, or
  - (cand & ~pe_in) != 0.
  - On that error no grant is loaded: cmd_valid <= 0, go to IDLE.
- Fairness: with all banks continuously requesting and cmd_ready=1, grants visit banks in order ptr, ptr+1, ... with wrap. No bank waits more than NUM_BNK_TOT-1 grants.
- Reset asserted mid-HOLD: all outputs clear immediately, with no handshake completion.

Test Plan:
- Reset then bank_req=16'h0000 for 10 cycles -> cmd_valid=0, rr_ptr=0, pe_err=0 throughout.
- bank_req=16'h0024, cmd_ready=1 constantly:
  - Grant sequence idx 2, 5, 2, 5 on consecutive cycles after the first.
  - rr_ptr goes 3, 6, 3, ...
- bank_req=16'hFFFF, rr_ptr=15 (reached via prior grants), cmd_ready=1 -> grant idx 15, then 0, then 1; rr_ptr wraps 0, 1, 2.
- Grant idx 4 held with cmd_ready=0 for 5 cycles while bank 7 toggles -> grant_oh=16'h0010 stable.
- Then cmd_ready=1 -> accepted, rr_ptr=5, next grant idx 7.
- Grant idx 3 held, cmd_ready=0, then bank_block[3]=1 -> cmd_valid drops next cycle, rr_ptr unchanged, re-grant of another requester one cycle later.
- Encoder model forced to return 16'h0003 on row 0 with bank_req=16'h0001 -> pe_err=1 and stays 1, no grant issued; rst_n low clears it.
